// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and default hold limit for the arbiter.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W = 3;
  localparam int DEF_MAX_HOLD = 15;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/hex7seg.sv
// hex7seg: hex digit to active-high seven-segment pattern, bit order gfedcba.
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
endmodule

// File: rtl/rr_prio_enc8.sv
// rr_prio_enc8: rotated priority encoder, first set req bit scanning upward from ptr (mod 8).
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  // Scan farthest offset first so the nearest set bit overwrites it last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + ID_W'(i)]) begin
        any = 1'b1;
        idx = ptr + ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/arb8_rr_ctrl.sv
// arb8_rr_ctrl: 8-way round-robin ownership arbiter with registered grant and 7-seg owner display.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module arb8_rr_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout,
  output logic [7:0]         seg
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, ptr_nx, id_nx, win;
  logic [NUM_REQ-1:0] gnt_nx;
  logic to_nx, any, hold_done;
  logic [6:0] pat;
  rr_prio_enc8 u_enc (.req(req), .ptr(ptr), .any(any), .idx(win));
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign hold_done = (state == GRANT) && (cnt == 8'(MAX_HOLD));
  always_ff @(posedge clk) begin
    if (!rst_n || state_nx != GRANT) cnt <= '0;
    else cnt <= cnt + 8'd1;
  end
`else
  assign hold_done = 1'b0;
`endif
  // gnt_id doubles as the owner register while in GRANT; it is zero in IDLE.
  always_comb begin
    state_nx = state;
    id_nx = gnt_id;
    ptr_nx = ptr;
    to_nx = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      id_nx = '0;
    end else if (state == IDLE) begin
      if (any) begin
        state_nx = GRANT;
        id_nx = win;
        ptr_nx = win + 3'd1;
      end
    end else if (!req[gnt_id] || hold_done) begin
      state_nx = IDLE;
      id_nx = '0;
      to_nx = req[gnt_id];
    end
  end
  assign gnt_nx = (state_nx == GRANT) ? 8'd1 << id_nx : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      ptr <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      gnt_id <= id_nx;
      ptr <= ptr_nx;
      timeout <= to_nx;
    end
  end
  assign gnt_valid = |gnt;
  hex7seg u_hex (.hex({1'b0, gnt_id}), .seg(pat));
  assign seg = gnt_valid ? {1'b1, ~pat} : 8'hFF;
endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// tb_arb8_rr_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_arb8_rr_ctrl;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt, seg;
  logic gnt_valid, timeout;
  logic [2:0] gnt_id;
  int n_tests = 0, n_fail = 0;
  int m_own = -1, m_ptr = 0, m_hold = 0;
  bit m_to = 1'b0;
  logic [6:0] digit [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  arb8_rr_ctrl #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!en) m_own = -1;
      else if (m_own < 0) begin
        for (int j = 0; j < 8; j++)
          if (m_own < 0 && req[(m_ptr + j) % 8]) m_own = (m_ptr + j) % 8;
        if (m_own >= 0) begin
          m_ptr = (m_own + 1) % 8;
          m_hold = 1;
        end
      end else if (!req[m_own]) m_own = -1;
      else if (TO_EN && m_hold == MH) begin
        m_own = -1;
        m_to = 1'b1;
      end else m_hold++;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eg, es;
    eg = (m_own < 0) ? 8'h00 : 8'(1 << m_own);
    es = (m_own < 0) ? 8'hFF : ~{1'b0, digit[m_own]};
    check("gnt", gnt, eg);
    check("gnt_valid", gnt_valid, m_own >= 0);
    check("gnt_id", gnt_id, (m_own < 0) ? 0 : m_own);
    check("timeout", timeout, m_to);
    check("seg", seg, es);
    check("onehot0", $onehot0(gnt), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    en = 1'b1;
    do_reset();
    check("rst_gnt", gnt, 8'h00);
    check("rst_seg", seg, 8'hFF);
    req = 8'h81; step();
    check("t029_g0", gnt, 8'h01);
    check("t029_id0", gnt_id, 0);
    req = 8'h80; step();
    check("t029_idle", gnt, 8'h00);
    step();
    check("t029_g7", gnt, 8'h80);
    check("t029_id7", gnt_id, 7);
    req = 8'h00; step();
    do_reset();
    req = 8'hFF; step();
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("t030_id%0d", k), gnt_id, k % 8);
      check($sformatf("t030_v%0d", k), gnt_valid, 1);
      step();
      req[k % 8] = 1'b0; step();
      check($sformatf("t030_gap%0d", k), gnt, 8'h00);
      req[k % 8] = 1'b1; step();
    end
    req = 8'h00; step(); step();
    do_reset();
    req = 8'h08; step();
    check("t031_g3", gnt, 8'h08);
    en = 1'b0; step();
    check("t031_off", gnt, 8'h00);
    req = 8'h09; step();
    check("t031_blk", gnt, 8'h00);
    en = 1'b1; step();
    check("t031_rot", gnt, 8'h01);
    req = 8'h00; step();
    if (TO_EN) begin
      do_reset();
      req = 8'h06; step();
      n = 0;
      while (gnt == 8'h02 && n < 20) begin
        n++;
        step();
      end
      check("t032_len", n, MH);
      check("t032_to", timeout, 1);
      step();
      check("t032_g2", gnt, 8'h04);
      check("t032_to_once", timeout, 0);
      req = 8'h00; step();
    end
    do_reset();
    req = 8'h20; step();
    check("t033_g5", gnt, 8'h20);
    rst_n = 1'b0; step();
    check("t033_rst", {gnt, gnt_valid, gnt_id, timeout}, 0);
    check("t033_seg", seg, 8'hFF);
    rst_n = 1'b1; req = 8'h24; step();
    check("t033_g2", gnt, 8'h04);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      en = ($urandom_range(0, 19) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
